// File: rtl/insn_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

  localparam int FETCH_ADDR_W = 9;
  localparam int FETCH_INSN_W = 32;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_BUBBLE,
    IFID_LOAD
  } ifid_ctl_t;

  // Reference layout of the IF/ID register at the default widths
  typedef struct packed {
    logic                    valid;
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_ADDR_W-1:0] pc_plus4;
    logic [FETCH_INSN_W-1:0] insn;
  } ifid_t;

endpackage

// File: rtl/insn_fetch_if.sv
// Instruction memory port: fetch drives the byte address, memory returns the word.
interface insn_fetch_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int INSN_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [INSN_WIDTH-1:0] insn;

  modport master (output addr, input insn);
  modport slave  (input addr, output insn);
endinterface

// File: rtl/insn_fetch_ifid_reg.sv
// IF/ID pipeline register with hold, bubble and load controls.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int INSN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ifid_ctl_t             ctl,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  input  logic [INSN_WIDTH-1:0] load_insn,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [INSN_WIDTH-1:0] insn
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= '0;
      pc_plus4 <= ADDR_WIDTH'(4);
      insn     <= INSN_WIDTH'(NOP_INSN);
    end else begin
      case (ctl)
        IFID_LOAD: begin
          valid    <= 1'b1;
          pc       <= load_pc;
          pc_plus4 <= load_pc + ADDR_WIDTH'(4);
          insn     <= load_insn;
        end
        // pc fields keep their previous value so bubbles stay deterministic
        IFID_BUBBLE: begin
          valid <= 1'b0;
          insn  <= INSN_WIDTH'(NOP_INSN);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/insn_fetch.sv
// Fetch stage: owns the PC, next-PC selection and the RUN/HALTED/FAULT sequencing.
//   state  | meaning
//   RUN    | fetching sequentially, honouring stall/flush/redirect
//   HALTED | ECALL captured in IF/ID, PC frozen until a redirect
//   FAULT  | misaligned redirect seen, frozen until reset
module insn_fetch
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  insn_fetch_if.master          imem,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ifid_valid,
  output logic [ADDR_WIDTH-1:0] ifid_pc,
  output logic [ADDR_WIDTH-1:0] ifid_pc_plus4,
  output logic [INSN_WIDTH-1:0] ifid_insn,
  output logic                  fetch_fault,
  output logic                  halted
);

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, pc_seq;
  ifid_ctl_t             ifid_ctl;
  logic                  misaligned;

  assign pc_seq     = pc + ADDR_WIDTH'(4);
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ifid_ctl  = IFID_HOLD;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          pc_nxt   = redirect_pc;
          ifid_ctl = IFID_BUBBLE;
          if (misaligned) state_nxt = FAULT;
        end else if (stall) begin
          ifid_ctl = flush ? IFID_BUBBLE : IFID_HOLD;
        end else if (flush) begin
          pc_nxt   = pc_seq;
          ifid_ctl = IFID_BUBBLE;
        end else begin
          pc_nxt   = pc_seq;
          ifid_ctl = IFID_LOAD;
          if (imem.insn == INSN_WIDTH'(ECALL_INSN)) state_nxt = HALTED;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          ifid_ctl  = IFID_BUBBLE;
          state_nxt = misaligned ? FAULT : RUN;
        end else if (flush) begin
          ifid_ctl = IFID_BUBBLE;
        end
      end
      default: ;
    endcase
  end

  assign imem.addr   = pc;
  assign halted      = (state == HALTED);
  assign fetch_fault = (state == FAULT);

  ifid_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INSN_WIDTH(INSN_WIDTH)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .ctl      (ifid_ctl),
    .load_pc  (pc),
    .load_insn(imem.insn),
    .valid    (ifid_valid),
    .pc       (ifid_pc),
    .pc_plus4 (ifid_pc_plus4),
    .insn     (ifid_insn)
  );

endmodule

// File: tb/tb_insn_fetch.sv
// Directed plus randomized check of insn_fetch against a cycle-level reference model.
module tb_insn_fetch;
  import fetch_pkg::*;

  localparam int AW = 9;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          ifid_valid;
  logic [AW-1:0] ifid_pc, ifid_pc_plus4;
  logic [IW-1:0] ifid_insn;
  logic          fetch_fault, halted;

  logic [IW-1:0] mem [128];

  int vectors = 0;
  int errors  = 0;

  // reference model state
  logic [AW-1:0] m_pc;
  ifid_t         m_ifid;
  bit            m_halted, m_fault;

  insn_fetch_if #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) imem ();

  assign imem.insn = mem[imem.addr[8:2]];

  insn_fetch #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_insn     (ifid_insn),
    .fetch_fault   (fetch_fault),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void bubble();
    m_ifid.valid = 1'b0;
    m_ifid.insn  = NOP_INSN;
  endfunction

  // Advance the model by one edge from the spec's rules
  function automatic void model_edge();
    logic [IW-1:0] word;
    word = mem[m_pc[8:2]];
    if (rst) begin
      m_pc = '0;
      m_ifid = '{valid: 1'b0, pc: '0, pc_plus4: 9'd4, insn: NOP_INSN};
      m_halted = 0;
      m_fault  = 0;
    end else if (m_fault) begin
      // frozen
    end else if (redirect_valid) begin
      m_pc = redirect_pc;
      bubble();
      m_halted = 0;
      if (redirect_pc[1:0] != 2'b00) m_fault = 1;
    end else if (m_halted) begin
      if (flush) bubble();
    end else if (stall) begin
      if (flush) bubble();
    end else if (flush) begin
      m_pc = m_pc + 9'd4;
      bubble();
    end else begin
      m_ifid = '{valid: 1'b1, pc: m_pc, pc_plus4: m_pc + 9'd4, insn: word};
      m_pc = m_pc + 9'd4;
      if (word == ECALL_INSN) m_halted = 1;
    end
  endfunction

  task automatic step(input bit r, input bit rv, input logic [AW-1:0] rpc,
                      input bit st, input bit fl);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    flush          = fl;
    model_edge();
    @(posedge clk);
    #1;
    check("imem_addr",     32'(imem.addr),     32'(m_pc));
    check("ifid_valid",    32'(ifid_valid),    32'(m_ifid.valid));
    check("ifid_pc",       32'(ifid_pc),       32'(m_ifid.pc));
    check("ifid_pc_plus4", 32'(ifid_pc_plus4), 32'(m_ifid.pc_plus4));
    check("ifid_insn",     ifid_insn,          m_ifid.insn);
    check("halted",        32'(halted),        32'(m_halted));
    check("fetch_fault",   32'(fetch_fault),   32'(m_fault));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  function automatic void fill_seq();
    for (int i = 0; i < 128; i++)
      mem[i] = {12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13};
  endfunction

  initial begin
    fill_seq();
    m_pc = '0;
    m_ifid = '0;
    m_halted = 0;
    m_fault = 0;
    @(negedge clk);

    // reset, free-run, 3-cycle stall at PC 8
    step(1, 0, '0, 0, 0);
    check("reset_insn_nop", ifid_insn, NOP_INSN);
    check("reset_pc4", 32'(ifid_pc_plus4), 32'd4);
    run(2);
    check("pc_at_8", 32'(imem.addr), 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 1, 0);
      check("stall_hold_pc", 32'(imem.addr), 32'h8);
      check("stall_hold_ifid", 32'(ifid_pc), 32'h4);
    end
    run(1);
    check("resume_12", 32'(imem.addr), 32'hC);

    // redirect overrides stall
    step(0, 1, 9'h040, 1, 0);
    check("redir_pc", 32'(imem.addr), 32'h40);
    check("redir_bubble", 32'(ifid_valid), 32'd0);
    run(1);
    check("redir_fetch", ifid_insn, mem[16]);
    step(0, 1, 9'h080, 0, 1);
    run(2);

    // misaligned redirect is terminal until reset
    step(0, 1, 9'h042, 0, 0);
    check("fault_set", 32'(fetch_fault), 32'd1);
    step(0, 1, 9'h020, 0, 0);
    run(2);
    check("fault_pc_held", 32'(imem.addr), 32'h42);
    step(1, 1, 9'h100, 0, 0);
    check("fault_cleared", 32'(fetch_fault), 32'd0);
    check("reset_pc", 32'(imem.addr), 32'h0);

    // ECALL at 0x10, stall ignored, flush clears, redirect resumes
    mem[4] = ECALL_INSN;
    run(5);
    check("halted_set", 32'(halted), 32'd1);
    check("halted_pc", 32'(imem.addr), 32'h14);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    step(0, 1, 9'h020, 0, 0);
    check("halt_cleared", 32'(halted), 32'd0);
    run(1);
    check("fetch_20", ifid_insn, mem[8]);
    fill_seq();

    // wrap past the top of memory
    step(0, 1, 9'h1FC, 0, 0);
    run(1);
    check("wrap_pc", 32'(imem.addr), 32'h0);
    check("wrap_pc4", 32'(ifid_pc_plus4), 32'h0);
    run(1);

    // randomized phase
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? ECALL_INSN : $urandom;
    for (int i = 0; i < 600; i++) begin
      bit r, rv, st, fl;
      logic [AW-1:0] rpc;
      r   = m_fault ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 11) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      rpc = AW'($urandom);
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      step(r, rv, rpc, st, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
